cla_seq_adder: RTL and testbench



---
 rtl/cla_seq_pkg.sv | 26 ++
 rtl/cla_seq_if.sv | 44 ++++
 rtl/cla_seq_adder_cla.sv | 36 +++
 rtl/cla_seq_adder.sv | 155 +++++++++++++++
 tb/tb_cla_seq_adder.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/cla_seq_pkg.sv
// +----------------------------------------------------------------------------+
// | cla_seq_pkg : shared types and constants for the nibble-serial CLA adder    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package cla_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int NIB_W = 4;

   // Nibble counter width; at least one bit even for degenerate widths.
   function automatic int cnt_width(input int width);
      int nib;
      nib = width / NIB_W;
      return (nib > 1) ? $clog2(nib) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cla_seq_if.sv
// +----------------------------------------------------------------------------+
// | cla_seq_if : operand/result handshake bundle for cla_seq_adder              |
// | Optional ovf signal is present only with CLA_SEQ_OVF_EN defined.            |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

interface cla_seq_if #(
   parameter int WIDTH = 16
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;
`ifdef CLA_SEQ_OVF_EN
   logic             ovf;
`endif

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, busy
`ifdef CLA_SEQ_OVF_EN
      , ovf
`endif
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, busy
`ifdef CLA_SEQ_OVF_EN
      , ovf
`endif
   );

endinterface

`default_nettype wire

// File: rtl/cla_seq_adder_cla.sv
// +----------------------------------------------------------------------------+
// | carry_look_ahead : 4-bit combinational carry look-ahead adder slice         |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module carry_look_ahead (
   input  wire logic [3:0] a,
   input  wire logic [3:0] b,
   input  wire logic       cin,
   output logic      [3:0] sum,
   output logic            cout
);

   logic [3:0] w_p;
   logic [3:0] w_g;
   logic [4:0] w_c;

   assign w_p = a ^ b;
   assign w_g = a & b;

   assign w_c[0] = cin;
   assign w_c[1] = w_g[0] | (w_p[0] & cin);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & cin);
   assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

   assign sum  = w_p ^ w_c[3:0];
   assign cout = w_c[4];

endmodule

`default_nettype wire

// File: rtl/cla_seq_adder.sv
// +----------------------------------------------------------------------------+
// | cla_seq_adder : nibble-serial WIDTH-bit adder sharing one 4-bit CLA slice   |
// | Optional signed-overflow output enabled by defining CLA_SEQ_OVF_EN.         |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module cla_seq_adder
   import cla_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  wire logic clk,
   input  wire logic rst_n,
   cla_seq_if.slave  bus
);

   localparam int              NIB    = WIDTH / NIB_W;
   localparam int              CW     = cnt_width(WIDTH);
   localparam logic [CW-1:0]   c_last = CW'(NIB - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_cout;
   logic [CW-1:0]    r_cnt;

   logic             w_accept;
   logic             w_last;
   logic             w_in_ready;
   logic             w_out_valid;
   logic             w_busy;

   logic [WIDTH-1:0] w_a_sh;
   logic [WIDTH-1:0] w_b_sh;
   logic [3:0]       w_s_nib;
   logic             w_co;

   // Nibble k of each operand is brought down to bit 0 for the slice.
   assign w_a_sh = r_a >> {r_cnt, 2'b00};
   assign w_b_sh = r_b >> {r_cnt, 2'b00};

   carry_look_ahead u_cla (
      .a    (w_a_sh[3:0]),
      .b    (w_b_sh[3:0]),
      .cin  (r_carry),
      .sum  (w_s_nib),
      .cout (w_co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_busy      = 1'b1;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         IDLE: begin
            w_in_ready = 1'b1;
            w_busy     = 1'b0;
            if (bus.in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (r_cnt == c_last) begin
               w_last      = 1'b1;
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            w_out_valid = 1'b1;
            if (bus.out_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_busy      = 1'b0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   // The carry register is seeded with cin so nibble 0 needs no special mux.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_a     <= bus.a;
         r_b     <= bus.b;
         r_carry <= bus.cin;
         r_sum   <= '0;
         r_cnt   <= '0;
      end else if (r_state == RUN) begin
         for (int i = 0; i < NIB; i++) begin
            if (r_cnt == CW'(i)) begin
               r_sum[i*NIB_W +: NIB_W] <= w_s_nib;
            end
         end
         r_carry <= w_co;
         if (w_last) begin
            r_cout <= w_co;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

`ifdef CLA_SEQ_OVF_EN
   logic r_ovf;
   logic w_c_top;

   // Carry into the MSB recovered from the top-nibble operand and sum bits.
   assign w_c_top = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_s_nib[3];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_accept) begin
         r_ovf <= 1'b0;
      end else if (w_last) begin
         r_ovf <= w_c_top ^ w_co;
      end
   end

   assign bus.ovf = r_ovf;
`endif

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.busy      = w_busy;
   assign bus.sum       = r_sum;
   assign bus.cout      = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_cla_seq_adder.sv
// +----------------------------------------------------------------------------+
// | tb_cla_seq_adder : directed self-checking bench for cla_seq_adder (16-bit)  |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cla_seq_adder;

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   cla_seq_if #(.WIDTH(16)) bus ();

   cla_seq_adder #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, ":in_ready"},  32'(bus.in_ready),  32'd1);
      check({tag, ":out_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, ":busy"},      32'(bus.busy),      32'd0);
      check({tag, ":sum"},       32'(bus.sum),       32'd0);
      check({tag, ":cout"},      32'(bus.cout),      32'd0);
`ifdef CLA_SEQ_OVF_EN
      check({tag, ":ovf"},       32'(bus.ovf),       32'd0);
`endif
   endtask

   // Called at a negedge with the block in IDLE; returns at a negedge in IDLE.
   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [15:0] es, input logic ec,
                         input logic eo, input int hold);
      int   n;
      logic bad_ready;
      bus.a        = a;
      bus.b        = b;
      bus.cin      = cin;
      bus.in_valid = 1'b1;
      check({tag, ":in_ready_idle"}, 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.a        = ~a;
      bus.b        = ~b;
      bus.cin      = ~cin;
      check({tag, ":busy_run"}, 32'(bus.busy), 32'd1);
      n         = 0;
      bad_ready = 1'b0;
      while (!bus.out_valid && n < 20) begin
         if (bus.in_ready !== 1'b0) bad_ready = 1'b1;
         @(negedge clk);
         n++;
      end
      check({tag, ":latency"},        32'(n),        32'd4);
      check({tag, ":in_ready_low"},   32'(bad_ready), 32'd0);
      check({tag, ":in_ready_done"},  32'(bus.in_ready), 32'd0);
      check({tag, ":sum"},            32'(bus.sum),  32'(es));
      check({tag, ":cout"},           32'(bus.cout), 32'(ec));
`ifdef CLA_SEQ_OVF_EN
      check({tag, ":ovf"},            32'(bus.ovf),  32'(eo));
`endif
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check({tag, ":hold_valid"}, 32'(bus.out_valid), 32'd1);
         check({tag, ":hold_sum"},   32'(bus.sum),       32'(es));
         check({tag, ":hold_cout"},  32'(bus.cout),      32'(ec));
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check({tag, ":exit_valid"},  32'(bus.out_valid), 32'd0);
      check({tag, ":exit_ready"},  32'(bus.in_ready),  32'd1);
      check({tag, ":exit_busy"},   32'(bus.busy),      32'd0);
   endtask

   initial begin
      logic seen_valid;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      bus.out_ready = 1'b0;
      #12;
      check_reset_values("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_op("zero",    16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 0);
      run_op("simple",  16'h0003, 16'h0001, 1'b0, 16'h0004, 1'b0, 1'b0, 0);
      run_op("ripple",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
      run_op("carryin", 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 0);
`ifdef CLA_SEQ_OVF_EN
      run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
      run_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
`endif
      run_op("backpr",  16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 3);
      run_op("mixed",   16'hA5C3, 16'h5A4E, 1'b1, 16'h0012, 1'b1, 1'b0, 0);

      // Abort an operation while nibble 2 is in the slice.
      bus.a        = 16'h1111;
      bus.b        = 16'h2222;
      bus.cin      = 1'b0;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("abort:busy_before", 32'(bus.busy), 32'd1);
      check("abort:partial_sum", 32'(bus.sum),  32'h0033);
      rst_n = 1'b0;
      #1;
      check_reset_values("abort");
      @(negedge clk);
      rst_n      = 1'b1;
      seen_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0) seen_valid = 1'b1;
      end
      check("abort:no_out_valid", 32'(seen_valid), 32'd0);
      check("abort:idle_after",   32'(bus.in_ready), 32'd1);

      run_op("after_abort", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
